// File: rtl/mdr_mem_unit.sv
// ============================================================================
// Module   : mdr_mem_unit
// Brief    : Memory data register with a read/write memory handshake FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdr_mem_unit #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [31:0]       BusMuxOut,
    input  logic              MDRin,
    input  logic              rd_start,
    input  logic              wr_start,
    input  logic [ADDR_W-1:0] mar_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [31:0]       BusMuxIn_MDR,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_REQ = 2'd1,
        WR_REQ = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] c_to_last = 8'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [31:0]         mdr_q, mdr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                err_q, err_d;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            mdr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mdr_q   <= mdr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mdr_d   = mdr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (MDRin) begin
                    mdr_d = BusMuxOut;
                end
                // A simultaneous write request is dropped in favour of the read.
                if (rd_start) begin
                    state_d = RD_REQ;
                    addr_d  = mar_addr;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end else if (wr_start) begin
                    state_d = WR_REQ;
                    addr_d  = mar_addr;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    wdata_d = MDRin ? BusMuxOut : mdr_q;
                end
            end

            RD_REQ, WR_REQ: begin
                // An ack on the timeout edge still counts as a normal completion.
                if (mem_ack) begin
                    state_d = DONE;
                    if (state_q == RD_REQ) begin
                        mdr_d = mem_rdata;
                    end
                end else if (cnt_q == c_to_last) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            DONE: begin
                if (MDRin) begin
                    mdr_d = BusMuxOut;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_req      = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign mem_we       = (state_q == WR_REQ);
    assign busy         = mem_req;
    assign done         = (state_q == DONE);
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign BusMuxIn_MDR = mdr_q;
    assign timeout_err  = err_q;

endmodule

`default_nettype wire

// File: doc/mdr_mem_unit.md
MDR_MEM_UNIT -- requirements
Module: mdr_mem_unit

Interface
REQ-001 Parameter ADDR_W, default 9, memory address width in bits.
REQ-002 Parameter TIMEOUT, default 15, maximum number of cycles mem_req is held without mem_ack; legal range 1..255.
REQ-003 clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 clear  input  1  reset, asynchronous and active-high.
REQ-005 BusMuxOut  input  32  bus value, the source for MDR loads and write data.
REQ-006 MDRin  input  1  load enable, MDR <= BusMuxOut.
REQ-007 rd_start  input  1  single-cycle request to read memory into MDR.
REQ-008 wr_start  input  1  single-cycle request to write MDR to memory.
REQ-009 mar_addr  input  ADDR_W  address, sampled when a request is accepted.
REQ-010 mem_rdata  input  32  memory read data, valid when mem_ack is high.
REQ-011 mem_ack  input  1  memory completion strobe.
REQ-012 mem_req  output  1  memory request, held until ack or timeout.
REQ-013 mem_we  output  1  1 = write and 0 = read; valid while mem_req is high.
REQ-014 mem_addr  output  ADDR_W  latched request address.
REQ-015 mem_wdata  output  32  latched write data.
REQ-016 BusMuxIn_MDR  output  32  MDR contents, feeding bus mux input 21.
REQ-017 busy  output  1  high in RD_REQ and WR_REQ.
REQ-018 done  output  1  one-cycle pulse on completion or abort.
REQ-019 timeout_err  output  1  sticky flag, set when the last transaction aborted.

Function
REQ-020 The FSM SHALL have the states IDLE, RD_REQ, WR_REQ and DONE, all registered.
REQ-021 In IDLE, rd_start SHALL cause a transition to RD_REQ, and wr_start without rd_start SHALL cause a transition to WR_REQ.
REQ-022 When rd_start and wr_start are both high, the read SHALL be taken and the write SHALL be dropped.
REQ-023 On acceptance, mem_addr SHALL be loaded from mar_addr, timeout_err SHALL be cleared, and the wait counter SHALL be zeroed.
REQ-024 On wr_start acceptance, mem_wdata SHALL be loaded with BusMuxOut if MDRin is high that cycle, else with the current MDR value.
REQ-025 rd_start and wr_start SHALL be ignored in RD_REQ, WR_REQ and DONE, with no queueing.
REQ-026 mem_req SHALL be high exactly in RD_REQ and WR_REQ, and mem_we SHALL be high exactly in WR_REQ.
REQ-027 In a REQ state, mem_ack high at a clock edge SHALL cause a transition to DONE; in RD_REQ it SHALL also load MDR <= mem_rdata at that edge.
REQ-028 In a REQ state, when mem_ack is low the wait counter SHALL increment.
REQ-029 If the wait counter equals TIMEOUT-1 and mem_ack is low, the FSM SHALL go to DONE, set timeout_err, and leave MDR unchanged.
REQ-030 If mem_ack arrives on the same edge as the timeout condition, the ack SHALL win and no error is flagged.
REQ-031 DONE SHALL assert done for exactly one cycle and then return unconditionally to IDLE.
REQ-032 Minimum latency SHALL be: accept at edge N, mem_req high from N, ack sampled at N+1, done high in cycle N+1..N+2.
REQ-033 MDRin SHALL load BusMuxOut into MDR in IDLE and DONE, and SHALL be ignored in RD_REQ and WR_REQ.
REQ-034 If MDRin and rd_start coincide in IDLE, MDR SHALL load BusMuxOut and the later read data SHALL overwrite it.
REQ-035 mem_ack outside the REQ states SHALL be ignored.
REQ-036 BusMuxIn_MDR SHALL be driven directly from the MDR register, with no combinational path from inputs.

Reset
REQ-037 clear high SHALL immediately force state IDLE, clear MDR, mem_addr, mem_wdata and the counter to 0, and drive mem_req, mem_we, busy, done and timeout_err to 0.
REQ-038 clear asserted mid-transaction SHALL abort without a done pulse, and a later stale mem_ack SHALL be ignored.

Verification
REQ-039 MDRin=1 with BusMuxOut=0x12345678 in IDLE SHALL give BusMuxIn_MDR=0x12345678 the next cycle, with busy=0.
REQ-040 rd_start with mar_addr=0x05, mem_ack after 3 wait cycles and mem_rdata=0xCAFEF00D SHALL give mem_req high for 4 cycles, MDR=0xCAFEF00D, one done pulse, and timeout_err=0.
REQ-041 wr_start and MDRin together with BusMuxOut=0xA5A5A5A5 and mar_addr=0x1FF SHALL give mem_wdata=0xA5A5A5A5, mem_addr=0x1FF, and mem_we=1 until ack.
REQ-042 rd_start with no ack and TIMEOUT=15 SHALL hold mem_req for exactly 15 cycles, then give done and timeout_err=1 with MDR unchanged; the next rd_start SHALL clear timeout_err.
REQ-043 mem_ack on the 15th request cycle SHALL complete normally with timeout_err=0.
REQ-044 clear pulsed in the 2nd cycle of RD_REQ SHALL give immediate all-zero outputs, no done pulse, and an ignored ack one cycle later.
